// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared definitions for the IF/MEM SRAM arbiter.
//   - RegValueW : pipeline register value width (data and instruction width)
//   - AddrW     : SRAM word-address width
//   - NopWord   : instruction word handed to IF when it is not being served
//   - arb_state_e : sequencer states (idle, read, three-phase write)
//   - owner_e     : which requester owns the transfer in flight
package mem_arbiter_pkg;

  localparam int unsigned RegValueW = 16;
  localparam int unsigned AddrW     = 16;

  localparam logic [RegValueW-1:0] NopWord = 16'h0800;

  typedef enum logic [2:0] {
    ArbIdle,
    ArbRd,
    ArbWrSetup,
    ArbWrPulse,
    ArbWrHold
  } arb_state_e;

  typedef enum logic {
    OwnIf,
    OwnMem
  } owner_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: pipeline-side bus between the IF/MEM stages and mem_arbiter.
//   IF  : if_req, if_addr -> ; <- if_data, if_valid
//   MEM : mem_rd, mem_wr, mem_addr, mem_wdata -> ; <- mem_rdata, mem_valid
//   stall <- pipeline freeze request
// Modports: master = pipeline stages, slave = arbiter.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
);

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_data;
  logic              if_valid;

  logic              mem_rd;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_valid;

  logic              stall;

  modport master (
    output if_req, if_addr, mem_rd, mem_wr, mem_addr, mem_wdata,
    input  if_data, if_valid, mem_rdata, mem_valid, stall
  );

  modport slave (
    input  if_req, if_addr, mem_rd, mem_wr, mem_addr, mem_wdata,
    output if_data, if_valid, mem_rdata, mem_valid, stall
  );

endinterface

// File: rtl/mem_arbiter_sram_seq.sv
// mem_arbiter_sram_seq: SRAM sequencer (sram_seq) for mem_arbiter.
// Accepts one granted request while idle and runs it to completion:
//   read : IDLE -> RD -> IDLE, data captured at the closing edge of RD
//   write: IDLE -> WR_SETUP -> WR_PULSE -> WR_HOLD -> IDLE, we_n low only in WR_PULSE
// Ports:
//   clk, rst (sync, active-low)
//   gnt_valid/gnt_wr/gnt_owner/gnt_addr/gnt_wdata : granted request from the front end
//   idle                 : sequencer is in IDLE
//   if_data/if_valid     : captured instruction and its one-cycle valid
//   mem_rdata/mem_valid  : captured load data; valid also flags store completion
//   ram_addr/ram_dout/ram_drive/ram_en_n/ram_oe_n/ram_we_n : registered SRAM pins
//   ram_din              : SRAM read data
module mem_arbiter_sram_seq
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned       ADDR_W   = AddrW,
  parameter int unsigned       DATA_W   = RegValueW,
  parameter logic [DATA_W-1:0] NOP_WORD = NopWord
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              gnt_valid,
  input  logic              gnt_wr,
  input  owner_e            gnt_owner,
  input  logic [ADDR_W-1:0] gnt_addr,
  input  logic [DATA_W-1:0] gnt_wdata,
  output logic              idle,
  output logic [DATA_W-1:0] if_data,
  output logic              if_valid,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_valid,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_dout,
  input  logic [DATA_W-1:0] ram_din,
  output logic              ram_drive,
  output logic              ram_en_n,
  output logic              ram_oe_n,
  output logic              ram_we_n
);

  arb_state_e        state_q;
  owner_e            owner_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [DATA_W-1:0] ram_dout_q;
  logic              drive_q, en_n_q, oe_n_q, we_n_q;
  logic [DATA_W-1:0] if_data_q, mem_rdata_q;
  logic              if_valid_q, mem_valid_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      // Reset also aborts a write in flight; we_n returns high with the rest.
      state_q     <= ArbIdle;
      owner_q     <= OwnIf;
      ram_addr_q  <= '0;
      ram_dout_q  <= '0;
      drive_q     <= 1'b0;
      en_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      if_data_q   <= NOP_WORD;
      mem_rdata_q <= '0;
      if_valid_q  <= 1'b0;
      mem_valid_q <= 1'b0;
    end else begin
      if_valid_q  <= 1'b0;
      mem_valid_q <= 1'b0;
      unique case (state_q)
        ArbIdle: begin
          if (gnt_valid) begin
            ram_addr_q <= gnt_addr;
            owner_q    <= gnt_owner;
            en_n_q     <= 1'b0;
            if (gnt_wr) begin
              ram_dout_q <= gnt_wdata;
              drive_q    <= 1'b1;
              state_q    <= ArbWrSetup;
            end else begin
              oe_n_q  <= 1'b0;
              state_q <= ArbRd;
            end
          end
        end
        ArbRd: begin
          if (owner_q == OwnMem) begin
            mem_rdata_q <= ram_din;
            mem_valid_q <= 1'b1;
          end else begin
            if_data_q  <= ram_din;
            if_valid_q <= 1'b1;
          end
          oe_n_q  <= 1'b1;
          en_n_q  <= 1'b1;
          state_q <= ArbIdle;
        end
        ArbWrSetup: begin
          we_n_q  <= 1'b0;
          state_q <= ArbWrPulse;
        end
        ArbWrPulse: begin
          we_n_q  <= 1'b1;
          state_q <= ArbWrHold;
        end
        ArbWrHold: begin
          drive_q     <= 1'b0;
          en_n_q      <= 1'b1;
          mem_valid_q <= 1'b1;
          state_q     <= ArbIdle;
        end
        default: begin
          state_q <= ArbIdle;
        end
      endcase
    end
  end

  assign idle      = (state_q == ArbIdle);
  assign if_data   = if_data_q;
  assign if_valid  = if_valid_q;
  assign mem_rdata = mem_rdata_q;
  assign mem_valid = mem_valid_q;
  assign ram_addr  = ram_addr_q;
  assign ram_dout  = ram_dout_q;
  assign ram_drive = drive_q;
  assign ram_en_n  = en_n_q;
  assign ram_oe_n  = oe_n_q;
  assign ram_we_n  = we_n_q;

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one external SRAM between instruction fetch (IF) and the
// data memory stage (MEM). Priority mem_wr > mem_rd > if_req; one transfer at a time.
// Ports:
//   clk, rst (sync, active-low)
//   bus      : mem_arbiter_if.slave (IF/MEM request, response, stall)
//   ram_addr, ram_dout, ram_drive, ram_en_n, ram_oe_n, ram_we_n : SRAM pins (registered)
//   ram_din  : SRAM read data; the tristate itself is resolved above this block
// Build option:
//   MEM_ARB_NOP_INJECT_EN : if_data reads NOP_WORD whenever if_valid is low,
//                           otherwise if_data holds the last fetched instruction.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned       ADDR_W   = AddrW,
  parameter int unsigned       DATA_W   = RegValueW,
  parameter logic [DATA_W-1:0] NOP_WORD = NopWord
) (
  input  logic              clk,
  input  logic              rst,
  mem_arbiter_if.slave      bus,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_dout,
  input  logic [DATA_W-1:0] ram_din,
  output logic              ram_drive,
  output logic              ram_en_n,
  output logic              ram_oe_n,
  output logic              ram_we_n
);

  logic              any_req;
  logic              mem_sel;
  logic              gnt_wr;
  owner_e            gnt_owner;
  logic [ADDR_W-1:0] gnt_addr;
  logic              idle;
  logic [DATA_W-1:0] if_data_raw;
  logic              if_valid;

  // Arbitration front end; the sequencer only looks at it while idle.
  // A simultaneous mem_rd is ignored when mem_wr is set.
  always_comb begin
    any_req   = bus.mem_wr | bus.mem_rd | bus.if_req;
    mem_sel   = bus.mem_wr | bus.mem_rd;
    gnt_wr    = bus.mem_wr;
    gnt_owner = mem_sel ? OwnMem : OwnIf;
    gnt_addr  = mem_sel ? bus.mem_addr : bus.if_addr;
  end

  mem_arbiter_sram_seq #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .NOP_WORD (NOP_WORD)
  ) u_sram_seq (
    .clk       (clk),
    .rst       (rst),
    .gnt_valid (any_req),
    .gnt_wr    (gnt_wr),
    .gnt_owner (gnt_owner),
    .gnt_addr  (gnt_addr),
    .gnt_wdata (bus.mem_wdata),
    .idle      (idle),
    .if_data   (if_data_raw),
    .if_valid  (if_valid),
    .mem_rdata (bus.mem_rdata),
    .mem_valid (bus.mem_valid),
    .ram_addr  (ram_addr),
    .ram_dout  (ram_dout),
    .ram_din   (ram_din),
    .ram_drive (ram_drive),
    .ram_en_n  (ram_en_n),
    .ram_oe_n  (ram_oe_n),
    .ram_we_n  (ram_we_n)
  );

  // A pending request stalls even in its own valid cycle until the requester drops it.
  assign bus.stall    = !idle || any_req;
  assign bus.if_valid = if_valid;

`ifdef MEM_ARB_NOP_INJECT_EN
  // IF/ID latches a bubble on every cycle without a fresh instruction.
  assign bus.if_data = if_valid ? if_data_raw : NOP_WORD;
`else
  assign bus.if_data = if_data_raw;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed, table-driven bench for mem_arbiter with a behavioural SRAM.
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic [15:0] ram_addr;
  logic [15:0] ram_dout;
  logic [15:0] ram_din;
  logic        ram_drive, ram_en_n, ram_oe_n, ram_we_n;

  mem_arbiter_if bus ();

  mem_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .ram_addr  (ram_addr),
    .ram_dout  (ram_dout),
    .ram_din   (ram_din),
    .ram_drive (ram_drive),
    .ram_en_n  (ram_en_n),
    .ram_oe_n  (ram_oe_n),
    .ram_we_n  (ram_we_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural SRAM: combinational read while selected, write on an edge with we_n low.
  logic [15:0] sram [0:65535];
  logic [15:0] fetch_words [1:9];

  assign ram_din = (!ram_en_n && !ram_oe_n) ? sram[ram_addr] : 16'hdead;

  initial begin
    fetch_words[1] = 16'h690a; fetch_words[2] = 16'h6a0c; fetch_words[3] = 16'h6b90;
    fetch_words[4] = 16'h6c21; fetch_words[5] = 16'h6d42; fetch_words[6] = 16'h6e63;
    fetch_words[7] = 16'h6f84; fetch_words[8] = 16'h70a5; fetch_words[9] = 16'h10f7;
    for (int i = 1; i <= 9; i++) sram[i] = fetch_words[i];
    forever begin
      @(posedge clk);
      if (!ram_en_n && !ram_we_n && ram_drive) sram[ram_addr] = ram_dout;
    end
  end

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_if_hold = 16'h0800;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // if_data outside a valid cycle: bubble when injection is built in, else last fetch.
  task automatic check_if_idle_data(input string name);
`ifdef MEM_ARB_NOP_INJECT_EN
    check(name, bus.if_data, 16'h0800);
`else
    check(name, bus.if_data, exp_if_hold);
`endif
  endtask

  typedef struct {
    bit          wr;
    bit          own_if;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs [7];

  // Inputs are driven and outputs sampled on negedges, away from the active edge.
  task automatic run_vec(input vec_t v, input int idx);
    int cyc = 0, oe_low = 0, we_low = 0, bad_bus = 0, no_stall = 0, other_valid = 0;
    bit got = 0;
    string tag = $sformatf("vec%0d", idx);
    if (v.wr) begin
      bus.mem_wr = 1'b1; bus.mem_addr = v.addr; bus.mem_wdata = v.wdata;
    end else if (v.own_if) begin
      bus.if_req = 1'b1; bus.if_addr = v.addr;
    end else begin
      bus.mem_rd = 1'b1; bus.mem_addr = v.addr;
    end
    while (!got && cyc < 12) begin
      @(negedge clk);
      cyc++;
      if (!ram_oe_n) oe_low++;
      if (!ram_we_n) we_low++;
      if (!ram_en_n && (ram_addr !== v.addr ||
                        (v.wr && (ram_dout !== v.wdata || !ram_drive)))) bad_bus++;
      if (!bus.stall) no_stall++;
      if (v.own_if ? bus.mem_valid : bus.if_valid) other_valid++;
      if (v.own_if ? bus.if_valid : bus.mem_valid) got = 1'b1;
    end
    check({tag, "_valid_seen"}, 32'(got), 32'd1);
    check({tag, "_latency"}, cyc, v.lat);
    if (!v.wr) check({tag, "_rdata"}, v.own_if ? bus.if_data : bus.mem_rdata, v.exp);
    if (v.own_if && got) exp_if_hold = v.exp;
    bus.if_req = 1'b0; bus.mem_rd = 1'b0; bus.mem_wr = 1'b0;
    check({tag, "_oe_low_cycles"}, oe_low, v.wr ? 0 : 1);
    check({tag, "_we_low_cycles"}, we_low, v.wr ? 1 : 0);
    check({tag, "_bus_stable"}, bad_bus, 0);
    check({tag, "_stall_held"}, no_stall, 0);
    check({tag, "_other_valid"}, other_valid, 0);
    @(negedge clk);
    check({tag, "_valid_pulse_end"}, {30'd0, bus.if_valid, bus.mem_valid}, 32'd0);
    check({tag, "_stall_idle"}, 32'(bus.stall), 32'd0);
    check_if_idle_data({tag, "_if_data_idle"});
  endtask

  initial begin
    int cyc, idx, last, mem_cyc, if_cyc, stall_low, mv;

    vecs[0] = '{wr: 0, own_if: 1, addr: 16'h0003, wdata: 16'h0, exp: 16'h6b90, lat: 2};
    vecs[1] = '{wr: 1, own_if: 0, addr: 16'h8000, wdata: 16'hbeef, exp: 16'h0, lat: 4};
    vecs[2] = '{wr: 0, own_if: 0, addr: 16'h8000, wdata: 16'h0, exp: 16'hbeef, lat: 2};
    vecs[3] = '{wr: 0, own_if: 1, addr: 16'h0001, wdata: 16'h0, exp: 16'h690a, lat: 2};
    vecs[4] = '{wr: 1, own_if: 0, addr: 16'h0010, wdata: 16'h1234, exp: 16'h0, lat: 4};
    vecs[5] = '{wr: 0, own_if: 0, addr: 16'h0010, wdata: 16'h0, exp: 16'h1234, lat: 2};
    vecs[6] = '{wr: 0, own_if: 1, addr: 16'h0009, wdata: 16'h0, exp: 16'h10f7, lat: 2};

    rst = 1'b0;
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.mem_rd = 1'b0; bus.mem_wr = 1'b0; bus.mem_addr = '0; bus.mem_wdata = '0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_strobes", {28'd0, ram_en_n, ram_oe_n, ram_we_n, ram_drive}, 32'he);
    check("rst_ram_addr", ram_addr, 16'h0);
    check("rst_ram_dout", ram_dout, 16'h0);
    check("rst_valids", {30'd0, bus.if_valid, bus.mem_valid}, 32'd0);
    check("rst_if_data", bus.if_data, 16'h0800);
    check("rst_mem_rdata", bus.mem_rdata, 16'h0);
    check("rst_stall", 32'(bus.stall), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // IF and MEM together: MEM first, then IF; stall high throughout.
    bus.if_req = 1'b1; bus.if_addr = 16'h0001;
    bus.mem_rd = 1'b1; bus.mem_addr = 16'h8000;
    cyc = 0; mem_cyc = 0; if_cyc = 0; stall_low = 0;
    while ((bus.if_req || bus.mem_rd) && cyc < 12) begin
      @(negedge clk);
      cyc++;
      if (!bus.stall) stall_low++;
      if (bus.mem_valid && bus.mem_rd) begin
        mem_cyc = cyc;
        check("both_mem_rdata", bus.mem_rdata, 16'hbeef);
        bus.mem_rd = 1'b0;
      end
      if (bus.if_valid && bus.if_req) begin
        if_cyc = cyc;
        check("both_if_data", bus.if_data, 16'h690a);
        exp_if_hold = 16'h690a;
        bus.if_req = 1'b0;
      end
    end
    bus.if_req = 1'b0; bus.mem_rd = 1'b0;
    check("both_mem_cycle", mem_cyc, 2);
    check("both_if_cycle", if_cyc, 4);
    check("both_stall_high", stall_low, 0);
    @(negedge clk);

    // Reset during WR_PULSE aborts the write.
    bus.mem_wr = 1'b1; bus.mem_addr = 16'h0020; bus.mem_wdata = 16'h5555;
    @(negedge clk);
    check("abort_setup_we", 32'(ram_we_n), 32'd1);
    @(negedge clk);
    check("abort_pulse_we", 32'(ram_we_n), 32'd0);
    rst = 1'b0; bus.mem_wr = 1'b0;
    @(negedge clk);
    check("abort_strobes", {28'd0, ram_en_n, ram_oe_n, ram_we_n, ram_drive}, 32'he);
    check("abort_idle", 32'(bus.stall), 32'd0);
    rst = 1'b1;
    mv = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.mem_valid || !ram_we_n) mv++;
    end
    check("abort_no_valid", mv, 0);
    exp_if_hold = 16'h0800;

    // Back-to-back fetches of words 1..9: one if_valid every 2 cycles.
    bus.if_req = 1'b1; bus.if_addr = 16'h0001;
    cyc = 0; idx = 1; last = 0;
    while (idx <= 9 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (bus.if_valid) begin
        check($sformatf("b2b_data%0d", idx), bus.if_data, fetch_words[idx]);
        check($sformatf("b2b_gap%0d", idx), cyc - last, 2);
        exp_if_hold = fetch_words[idx];
        last = cyc;
        idx++;
        if (idx <= 9) bus.if_addr = 16'(idx);
        else bus.if_req = 1'b0;
      end else begin
        check_if_idle_data($sformatf("b2b_hold%0d", idx));
      end
    end
    bus.if_req = 1'b0;
    check("b2b_count", idx, 10);
    @(negedge clk);
    check("b2b_stall_after", 32'(bus.stall), 32'd0);
    check_if_idle_data("b2b_if_data_after");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
